// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
// Defaults match the ALU/address-generation configuration (32 bits, 4 slices).
package pipelined_adder_pkg;

  localparam int WIDTH_DEFAULT  = 32;
  localparam int STAGES_DEFAULT = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int slice_width(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit stages_legal(int width, int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master side presents operands and consumes results; the slave side is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = pipelined_adder_pkg::WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, x, y, ci, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, ci, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational SW-bit carry-chain slice; one instance per pipeline stage.
// Also reports the carry into its top bit so the last slice can form signed overflow.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb
);

  logic [SW:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
  assign s    = sum[SW-1:0];
  assign cout = sum[SW];
  // The sum bit of the top position is a ^ b ^ carry-in, so the carry-in falls out directly.
  assign c_msb = sum[SW-1] ^ a[SW-1] ^ b[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH split into STAGES carry slices, one slice per stage,
// with valid/ready backpressure (global stall) and a synchronous flush.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipelined_adder_if.slave  bus
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!stages_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  op_e              op;
  logic [WIDTH-1:0] yy0;
  logic             c0;
  logic             out_valid;
  logic             advance;

  // Subtraction is x + ~y + 1; the carry-in port only matters for addition.
  assign op  = op_e'(bus.sub);
  assign yy0 = (op == OP_SUB) ? ~bus.y : bus.y;
  assign c0  = (op == OP_SUB) ? 1'b1 : bus.ci;

  assign out_valid    = g_stage[STAGES-1].v_q;
  assign advance      = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] acc_in, yy_in, acc_nx;
    logic [WIDTH-1:0] acc_q, yy_q;
    logic             c_in, v_in;
    logic             c_q, v_q;
    logic [SW-1:0]    slice_s;
    logic             slice_c, slice_cm;

    // acc carries finished low slices plus still-unprocessed high slices of x.
    if (k == 0) begin : g_first
      assign acc_in = bus.x;
      assign yy_in  = yy0;
      assign c_in   = c0;
      assign v_in   = bus.in_valid;
    end else begin : g_next
      assign acc_in = g_stage[k-1].acc_q;
      assign yy_in  = g_stage[k-1].yy_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a     (acc_in[k*SW +: SW]),
      .b     (yy_in[k*SW +: SW]),
      .ci    (c_in),
      .s     (slice_s),
      .cout  (slice_c),
      .c_msb (slice_cm)
    );

    // NOTE: assign the whole vector first, then patch the slice; no path is left unassigned, so no latch.
    always_comb begin
      acc_nx               = acc_in;
      acc_nx[k*SW +: SW]   = slice_s;
    end

    // NOTE: datapath registers are reset as well, so s/cout/ovf/zero read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        acc_q <= '0;
        yy_q  <= '0;
      end else begin
        // Flush wins over stall: valid bits clear even when the output is held.
        if (flush)        v_q <= 1'b0;
        else if (advance) v_q <= v_in;
        if (advance) begin
          acc_q <= acc_nx;
          yy_q  <= yy_in;
          c_q   <= slice_c;
        end
      end
    end

    if (k == STAGES-1) begin : g_last
      logic ovf_q, zero_q;
      logic unused_yy;

      assign unused_yy = ^yy_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= slice_cm ^ slice_c;
          zero_q <= (acc_nx == '0);
        end
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = slice_cm;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.s         = g_stage[STAGES-1].acc_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign bus.zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule
